div_share_ctrl: RTL and testbench
=================================

# div_share_ctrl

Sequencer and arbiter that shares the ALU's single combinational 8-bit divider between two requesters. It accepts an operand pair from one requester at a time, drives the divider's dividend and divisor inputs, and holds them for a fixed number of settling cycles. It then captures the quotient and returns it on a tagged response channel. It sits between the ALU issue logic and the divider, turning a long combinational path into a multi-cycle, handshaked operation.

## Interface
- WIDTH, 8, operand/quotient width
- LAT, 2, settling cycles divider inputs are held before capture (legal ≥1)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle when valid
- req0_a / req0_b  in  WIDTH  requester 0 dividend / divisor
- req1_valid, req1_ready, req1_a, req1_b  same for requester 1
- div_a / div_b  out  WIDTH  to shared divider A / B
- div_c  in  WIDTH  quotient from shared divider
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester index of response
- rsp_q  out  WIDTH  quotient
- rsp_dz  out  1  divide-by-zero flag (present only with DIV_ZERO_BYPASS_EN)
- busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE → EXEC → RESP → IDLE.
- IDLE: grant chosen combinationally; reqN_ready = 1 only for the granted N, only in IDLE; other ready = 0.
- Grant: only one valid → that one; both valid → requester not granted last (round-robin pointer `last`); pointer reset value 1 so req0 wins first tie.
- Accept (valid & ready): latch a/b into operand regs, id into rsp_id reg, update `last`, load counter = LAT−1, go EXEC.
- div_a/div_b always driven from operand regs; hold value after operation until next accept.
- EXEC: counter decrements each cycle; at counter 0 capture div_c into rsp_q, go RESP.
- RESP: rsp_valid = 1, rsp_id/rsp_q stable; on rsp_ready go IDLE. No acceptance in the RESP cycle even if rsp_ready = 1.
- Quotient width = WIDTH; no remainder; captured unchanged from div_c.
- Requester valids during EXEC/RESP ignored (ready = 0); must be held until accepted.

## Timing
- Reset values: state IDLE, req0_ready/req1_ready follow IDLE grant rules (0 if no valid), div_a = div_b = 0, rsp_valid = 0, rsp_id = 0, rsp_q = 0, rsp_dz = 0, busy = 0, `last` = 1.
- Accept at edge ending cycle T → EXEC cycles T+1..T+LAT → rsp_valid first high in cycle T+LAT+1 (latency LAT+1).
- Earliest next accept: cycle after rsp_valid & rsp_ready; throughput one op per LAT+2 cycles with rsp_ready tied high.
- rsp_ready low: RESP holds indefinitely, outputs stable.
- rst high in any state: next cycle all reset values; in-flight op discarded, no response issued.

## Configuration
- DIV_ZERO_BYPASS_EN defined: rsp_dz port exists; accept with b = 0 goes IDLE → RESP directly, rsp_q = all ones (8'hFF), rsp_dz = 1, response at T+1; divider inputs still latched. rsp_dz = 0 for all nonzero divisors.
- Undefined: no rsp_dz port; b = 0 handled like any divisor, full LAT sequence, rsp_q = whatever div_c returns.

## Test plan
- Reset: rst high 2 cycles with req0_valid = 1 → req0_ready = 0 during rst, all outputs at reset values, busy = 0.
- Single op: LAT = 2, req0 a = 100, b = 7, rsp_ready = 1 → rsp_valid at T+3, rsp_id = 0, rsp_q = 14, div_a = 100, div_b = 7 during EXEC.
- Tie round-robin: both valid continuously, req0 (9/3), req1 (200/10) → responses in order id 0 q 3, id 1 q 20, id 0 q 3, alternating.
- Backpressure: rsp_ready low 5 cycles after rsp_valid → rsp_valid, rsp_q held; both readys 0; IDLE only after rsp_ready.
- Mid-op reset: rst asserted in EXEC → next cycle state IDLE, rsp_valid never rises for that op, `last` = 1.
- Divide by zero, DIV_ZERO_BYPASS_EN defined: req1 a = 5, b = 0 → rsp_valid at T+1, rsp_q = 8'hFF, rsp_dz = 1, rsp_id = 1; undefined: rsp_valid at T+LAT+1, no rsp_dz.

Source files
------------

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin sequencer sharing one combinational divider between two requesters.
// Optional DIV_ZERO_BYPASS_EN: zero divisors skip the divider and return 8'hFF with rsp_dz set.
module div_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_q,
`ifdef DIV_ZERO_BYPASS_EN
    output logic             rsp_dz,
`endif
    output logic             busy
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_q, w_a, w_b;
    logic [CW-1:0]    r_cnt;
    logic             r_id, r_last, w_gnt, w_acc, w_zero;
`ifdef DIV_ZERO_BYPASS_EN
    logic             r_dz;
    assign rsp_dz = r_dz;
`endif
    always_comb begin
        w_gnt = (req0_valid && req1_valid) ? ~r_last : req1_valid;
        w_acc = (r_state == IDLE) && !rst && (req0_valid || req1_valid);
        w_a = w_gnt ? req1_a : req0_a;
        w_b = w_gnt ? req1_b : req0_b;
`ifdef DIV_ZERO_BYPASS_EN
        w_zero = (w_b == '0);
`else
        w_zero = 1'b0;
`endif
        w_next = r_state;
        if (w_acc)
            w_next = w_zero ? RESP : EXEC;
        else if (r_state == EXEC && r_cnt == '0)
            w_next = RESP;
        else if (r_state == RESP && rsp_ready)
            w_next = IDLE;
    end
    assign req0_ready = w_acc && !w_gnt;
    assign req1_ready = w_acc && w_gnt;
    assign div_a      = r_a;
    assign div_b      = r_b;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_q      = r_q;
    assign busy       = (r_state != IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_a    <= w_a;
                r_b    <= w_b;
                r_id   <= w_gnt;
                r_last <= w_gnt;
                r_cnt  <= CW'(LAT - 1);
            end else if (r_state == EXEC) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // bypassed zero divisors never visit EXEC, so the all-ones quotient is loaded at accept
            if (w_acc && w_zero)
                r_q <= '1;
            else if (r_state == EXEC && r_cnt == '0)
                r_q <= div_c;
`ifdef DIV_ZERO_BYPASS_EN
            if (w_acc)
                r_dz <= w_zero;
`endif
        end
    end
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed and randomized checks of div_share_ctrl against a transaction-level model.
// Builds with or without DIV_ZERO_BYPASS_EN.
module tb_div_share_ctrl;
    localparam int WIDTH = 8;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [WIDTH-1:0] div_a, div_b, div_c, rsp_q;
`ifdef DIV_ZERO_BYPASS_EN
    logic rsp_dz;
`endif

    always #5 clk = ~clk;

    // external divider; a recognisable pattern on divide-by-zero
    assign div_c = (div_b == '0) ? 8'hA5 : div_a / div_b;

    div_share_ctrl #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .div_a(div_a), .div_b(div_b), .div_c(div_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
`ifdef DIV_ZERO_BYPASS_EN
        .rsp_dz(rsp_dz),
`endif
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int due     = 0;
    bit in_flight = 1'b0;
    bit last_srv  = 1'b1;
    bit exp_id    = 1'b0;
    bit exp_dz    = 1'b0;
    logic [WIDTH-1:0] exp_q = '0, exp_da = '0, exp_db = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock cycle: check outputs against the model, then advance the model
    task automatic step();
        bit g, rv, clr0, clr1;
        logic [WIDTH-1:0] a, b;
        clr0 = 1'b0;
        clr1 = 1'b0;
        #1;
        cyc++;
        rv = in_flight && (cyc >= due);
        chk("busy", busy, in_flight);
        chk("div_a", div_a, exp_da);
        chk("div_b", div_b, exp_db);
        chk("rsp_valid", rsp_valid, rv);
        if (rv) begin
            chk("rsp_id", rsp_id, exp_id);
            chk("rsp_q", rsp_q, exp_q);
`ifdef DIV_ZERO_BYPASS_EN
            chk("rsp_dz", rsp_dz, exp_dz);
`endif
        end
        if (in_flight || rst) begin
            chk("req0_ready", req0_ready, 0);
            chk("req1_ready", req1_ready, 0);
        end else begin
            chk("req0_ready", req0_ready, req0_valid && (!req1_valid || last_srv));
            chk("req1_ready", req1_ready, req1_valid && (!req0_valid || !last_srv));
        end
        if (rst) begin
            in_flight = 1'b0;
            last_srv  = 1'b1;
            exp_da    = '0;
            exp_db    = '0;
        end else if (in_flight) begin
            if (rv && rsp_ready) in_flight = 1'b0;
        end else if (req0_valid || req1_valid) begin
            g = (req0_valid && req1_valid) ? !last_srv : req1_valid;
            a = g ? req1_a : req0_a;
            b = g ? req1_b : req0_b;
            in_flight = 1'b1;
            last_srv  = g;
            exp_id    = g;
            exp_da    = a;
            exp_db    = b;
            due       = cyc + LAT + 1;
            exp_q     = (b == 0) ? 8'hA5 : a / b;
            exp_dz    = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            if (b == 0) begin
                due    = cyc + 1;
                exp_q  = 8'hFF;
                exp_dz = 1'b1;
            end
`endif
            clr0 = !g;
            clr1 = g;
        end
        @(negedge clk);
        if (clr0) req0_valid = 1'b0;
        if (clr1) req1_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        // reset with a requester already waiting
        req0_valid = 1'b1; req0_a = 8'd100; req0_b = 8'd7;
        repeat (2) step();
        chk("reset rsp_q", rsp_q, 0);
        chk("reset rsp_id", rsp_id, 0);
`ifdef DIV_ZERO_BYPASS_EN
        chk("reset rsp_dz", rsp_dz, 0);
`endif
        rst = 1'b0;
        rsp_ready = 1'b1;
        // single op 100/7
        repeat (6) step();
        chk("single q", rsp_q, 14);
        // tie round-robin
        for (int i = 0; i < 16; i++) begin
            req0_valid = 1'b1; req0_a = 8'd9;   req0_b = 8'd3;
            req1_valid = 1'b1; req1_a = 8'd200; req1_b = 8'd10;
            step();
        end
        while (req0_valid || req1_valid || in_flight) begin
            step();
            if (cyc > 200) break;
        end
        // backpressure
        req0_valid = 1'b1; req0_a = 8'd77; req0_b = 8'd5;
        rsp_ready = 1'b0;
        repeat (9) step();
        rsp_ready = 1'b1;
        repeat (2) step();
        // mid-op reset after req0 won, then a tie must go to req0 again
        req0_valid = 1'b1; req0_a = 8'd50; req0_b = 8'd2;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd9;   req0_b = 8'd3;
        req1_valid = 1'b1; req1_a = 8'd200; req1_b = 8'd10;
        repeat (10) step();
        // divide by zero on requester 1
        req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd0;
        repeat (6) step();
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 79) == 0);
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_a = 8'($urandom);
                req0_b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_a = 8'($urandom);
                req1_b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            end
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
